// File: rtl/trans_pkg.sv
// Shared types and constants for the 8x8 transpose buffer.
// A vector is N lanes of DW bits, lane j at bits [DW*j +: DW].
package trans_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = $clog2(N);

  typedef logic [DW-1:0] lane_t;
  typedef lane_t [N-1:0] vec_t;

  function automatic lane_t lane_of(input logic [N*DW-1:0] bus, input int unsigned j);
    return bus[DW*j +: DW];
  endfunction

endpackage

// File: rtl/trans_bank.sv
// One N x N element bank: row-wide write port, combinational column read mux.
module trans_bank
  import trans_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] wr_row,
  input  vec_t          wr_data,
  input  logic [IW-1:0] rd_col,
  output vec_t          rd_data
);

  vec_t [N-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Lane r of the read vector is element (r, rd_col).
  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < N; r++) begin
      rd_data[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/trans_col_reader.sv
// Ping-pong 8x8 transpose buffer: rows in, columns out, one vector per cycle each side.
module trans_col_reader
  import trans_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*DW-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*DW-1:0]  out_data,
  output logic             out_last
);

  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] rd_col;
  logic [1:0]    full;

  vec_t in_vec;
  vec_t rd_vec0;
  vec_t rd_vec1;
  logic wr_fire;
  logic rd_fire;

  always_comb begin
    in_vec = '0;
    for (int unsigned j = 0; j < N; j++) begin
      in_vec[j] = lane_of(in_data, j);
    end
  end

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_col == IW'(N-1));
  assign out_data  = rd_bank ? rd_vec1 : rd_vec0;

  // clr discards whatever handshake coincides with it, including the bank write.
  assign wr_fire = in_valid && in_ready && !clr;
  assign rd_fire = out_valid && out_ready && !clr;

  trans_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_fire && !wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_vec),
    .rd_col  (rd_col),
    .rd_data (rd_vec0)
  );

  trans_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_fire && wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_vec),
    .rd_col  (rd_col),
    .rd_data (rd_vec1)
  );

  // Set and clear never target the same full bit in one cycle: set needs !full, clear needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
      full    <= '0;
    end else if (clr) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
      full    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_row == IW'(N-1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_row        <= '0;
        end else begin
          wr_row <= wr_row + IW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_col == IW'(N-1)) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          rd_col        <= '0;
        end else begin
          rd_col <= rd_col + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trans_col_reader.sv
// Bench for trans_col_reader: queue-based block model checked every cycle, plus literal spot checks.
module tb_trans_col_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;

  int n_checks = 0;
  int n_fail   = 0;

  trans_col_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: complete blocks stored row-major (element (r,c) at r*8+c), 64 entries per block.
  logic [15:0] blk_q[$];
  logic [15:0] part_q[$];
  int          m_col = 0;

  function automatic int m_nblk();
    return blk_q.size() / 64;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || clr) begin
      blk_q.delete();
      part_q.delete();
      m_col = 0;
    end else begin
      int nb;
      bit wf, rf;
      nb = m_nblk();
      wf = in_valid && (nb < 2);
      rf = out_ready && (nb > 0);
      if (rf) begin
        m_col++;
        if (m_col == 8) begin
          repeat (64) void'(blk_q.pop_front());
          m_col = 0;
        end
      end
      if (wf) begin
        for (int c = 0; c < 8; c++) part_q.push_back(in_data[16*c +: 16]);
        if (part_q.size() == 64) begin
          foreach (part_q[i]) blk_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
    end
  end

  // Every cycle out of reset, compare outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int nb;
      logic [127:0] e;
      nb = m_nblk();
      chk("in_ready", in_ready, (nb < 2));
      chk("out_valid", out_valid, (nb > 0));
      if (nb > 0) begin
        e = '0;
        for (int r = 0; r < 8; r++) e[16*r +: 16] = blk_q[r*8 + m_col];
        chk("out_data", out_data, e);
        chk("out_last", out_last, (m_col == 7));
      end else begin
        chk("out_last_idle", out_last, 1'b0);
      end
    end
  end

  function automatic logic [127:0] pat(input int b, input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[16*c +: 16] = {4'(b), 4'(r), 4'h0, 4'(c)};
    return v;
  endfunction

  // Offers rows until nrows are accepted; acceptance predicted from model occupancy.
  task automatic send_rows(input int nrows, input int blk0, input bit rnd);
    int idx = 0;
    int budget = 0;
    bit have = 0;
    bit acc;
    logic [127:0] d;
    while (idx < nrows && budget < 4000) begin
      if (!have) begin
        d = rnd ? {$urandom, $urandom, $urandom, $urandom} : pat(blk0 + idx/8, idx%8);
        have = 1;
      end
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      in_data = d;
      acc = in_valid && (m_nblk() < 2);
      @(negedge clk);
      budget++;
      if (acc) begin
        idx++;
        have = 0;
      end
    end
    in_valid = 1'b0;
    chk("send_rows_budget", 128'(idx), 128'(nrows));
  endtask

  task automatic drain();
    int b = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (m_nblk() > 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("drain_empty", out_valid, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single block with literal expectations.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int r = 0; r < 8; r++) begin
      in_data = pat(0, r);
      @(negedge clk);
      if (r < 7) chk("sb_valid_early", out_valid, 1'b0);
      chk("sb_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    chk("sb_valid_rise", out_valid, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c == 3) chk("sb_col3", out_data, 128'h0703_0603_0503_0403_0303_0203_0103_0003);
      chk("sb_last", out_last, (c == 7));
      @(negedge clk);
    end
    chk("sb_done", out_valid, 1'b0);

    // Continuous streaming, four blocks.
    out_ready = 1'b1;
    send_rows(32, 1, 0);
    drain();

    // Backpressure: fill both banks with a stalled reader.
    out_ready = 1'b0;
    send_rows(16, 5, 0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_col0_stable", out_data, 128'h5700_5600_5500_5400_5300_5200_5100_5000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bp_in_ready_rise", in_ready, (k == 7));
    end
    drain();

    // clr mid-block with one full bank pending; the coincident row is discarded.
    out_ready = 1'b0;
    send_rows(8, 7, 0);
    send_rows(5, 8, 0);
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_data   = pat(8, 5);
    out_ready = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    send_rows(8, 11, 0);
    drain();

    // Random stalls on both sides.
    send_rows(40, 0, 1);
    drain();

    // Async reset while column 5 is presented.
    out_ready = 1'b0;
    send_rows(8, 9, 0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("ar_pre_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_out_data", out_data, '0);
    chk("ar_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    send_rows(8, 10, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
